// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
// Holds the FSM state enum, hardwired register indices and a clog2 helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DUMP
  } state_t;

  localparam int ZERO_IDX = 0;
  localparam int ONE_IDX  = 1;

  function automatic int pc_idx(input int nregs);
    return nregs - 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port; hardwired view, write bypass, output stage.
// Ports: clk/rst, busy, pc, raddr, mem_data, waddr/wdata/we, rdata.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int AW       = 5,
  parameter int NWR      = 2,
  parameter int REG_OUT  = 1,
  parameter int PC_DELTA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic [DATA_W-1:0]     pc,
  input  logic [AW-1:0]         raddr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NWR-1:0]        we,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] ZA = AW'(ZERO_IDX);
  localparam logic [AW-1:0] OA = AW'(ONE_IDX);
  localparam logic [AW-1:0] PA = AW'(pc_idx(NREGS));
  // The registered stage already delays by one, so the combinational
  // path pulls the PC view back by one.
  localparam logic [DATA_W-1:0] PC_OFF = (REG_OUT != 0)
    ? DATA_W'(PC_DELTA) : DATA_W'(PC_DELTA - 1);

  logic [DATA_W-1:0] byp;
  logic [DATA_W-1:0] view;
  logic [DATA_W-1:0] q;

  // Later ports overwrite earlier ones: highest index wins.
  always_comb begin
    byp = mem_data;
    for (int w = 0; w < NWR; w++)
      if (we[w] && waddr[w*AW +: AW] == raddr)
        byp = wdata[w*DATA_W +: DATA_W];
  end

  always_comb begin
    unique case (1'b1)
      raddr == ZA: view = '0;
      raddr == OA: view = DATA_W'(1);
      raddr == PA: view = pc + PC_OFF;
      default:     view = busy ? '0 : byp;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= view;
  end

  assign rdata = (REG_OUT != 0) ? q : view;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with clear sweep,
// write bypass and handshaked debug dump (dbg_valid/ready/idx/data/done).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int REG_OUT  = 1,
  parameter int PC_DELTA = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pc,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NWR-1:0]        we,
  output logic                  busy,
  input  logic                  dbg_start,
  output logic                  dbg_valid,
  input  logic                  dbg_ready,
  output logic [AW-1:0]         dbg_idx,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  dbg_done
);

  localparam logic [AW-1:0] ZA   = AW'(ZERO_IDX);
  localparam logic [AW-1:0] OA   = AW'(ONE_IDX);
  localparam logic [AW-1:0] LAST = AW'(pc_idx(NREGS));
  localparam logic [DATA_W-1:0] PC_OFF = (REG_OUT != 0)
    ? DATA_W'(PC_DELTA) : DATA_W'(PC_DELTA - 1);

  state_t            state;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] mem [NREGS];
  logic [NWR-1:0]    we_g;
  logic [DATA_W-1:0] dv;

  assign busy      = (state == CLEAR);
  assign dbg_valid = (state == DUMP);
  assign dbg_idx   = idx;
  assign we_g      = busy ? '0 : we;

  // Storage has no reset; the sweep defines it.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[idx] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (we_g[w])
          mem[waddr[w*AW +: AW]] <= wdata[w*DATA_W +: DATA_W];
    end
  end

  // idx is the sweep pointer in CLEAR and the word pointer in DUMP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      idx      <= '0;
      dbg_done <= 1'b0;
    end else begin
      dbg_done <= 1'b0;
      unique case (state)
        CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= IDLE;
        end
        IDLE: begin
          if (dbg_start) begin
            state <= DUMP;
            idx   <= '0;
          end
        end
        DUMP: begin
          if (dbg_ready) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state    <= IDLE;
              dbg_done <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    unique case (1'b1)
      idx == ZA:   dv = '0;
      idx == OA:   dv = DATA_W'(1);
      idx == LAST: dv = pc + PC_OFF;
      default:     dv = mem[idx];
    endcase
  end

  assign dbg_data = dbg_valid ? dv : '0;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .AW      (AW),
      .NWR     (NWR),
      .REG_OUT (REG_OUT),
      .PC_DELTA(PC_DELTA)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy),
      .pc      (pc),
      .raddr   (raddr[k*AW +: AW]),
      .mem_data(mem[raddr[k*AW +: AW]]),
      .waddr   (waddr),
      .wdata   (wdata),
      .we      (we_g),
      .rdata   (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, REG_OUT=1 and REG_OUT=0
// instances driven in lockstep; dump words checked on each handshake.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic [9:0]  raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        dbg_start;
  logic        dbg_ready;

  logic [63:0] rd1, rd0;
  logic        busy1, busy0;
  logic        dv1, dv0;
  logic [4:0]  didx1, didx0;
  logic [31:0] ddata1, ddata0;
  logic        ddone1, ddone0;

  regfile_mp #(.REG_OUT(1)) u1 (
    .clk(clk), .rst(rst), .pc(pc), .raddr(raddr), .rdata(rd1),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy1),
    .dbg_start(dbg_start), .dbg_valid(dv1), .dbg_ready(dbg_ready),
    .dbg_idx(didx1), .dbg_data(ddata1), .dbg_done(ddone1)
  );

  regfile_mp #(.REG_OUT(0)) u0 (
    .clk(clk), .rst(rst), .pc(pc), .raddr(raddr), .rdata(rd0),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy0),
    .dbg_start(dbg_start), .dbg_valid(dv0), .dbg_ready(dbg_ready),
    .dbg_idx(didx0), .dbg_data(ddata0), .dbg_done(ddone0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int RD1_0 = 0, RD1_1 = 1, RD0_0 = 2, RD0_1 = 3;
  localparam int BUSY1 = 4, BUSY0 = 5, DV = 6, DIDX = 7;
  localparam int DDATA = 8, DDONE = 9;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } dexp_t;

  exp_t  q[$];
  dexp_t dq[$];
  dexp_t de;
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    n;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] sel(int s);
    case (s)
      RD1_0:   return rd1[31:0];
      RD1_1:   return rd1[63:32];
      RD0_0:   return rd0[31:0];
      RD0_1:   return rd0[63:32];
      BUSY1:   return 32'(busy1);
      BUSY0:   return 32'(busy0);
      DV:      return 32'(dv1);
      DIDX:    return 32'(didx1);
      DDATA:   return ddata1;
      default: return 32'(ddone1);
    endcase
  endfunction

  function automatic logic [31:0] dump_val(int i);
    case (i)
      1:       return 32'h1;
      3:       return 32'h33;
      7:       return 32'h1234;
      9:       return 32'h5555;
      20:      return 32'h2020;
      31:      return 32'h101;
      default: return 32'h0;
    endcase
  endfunction

  task automatic expect_at(int dc, int s, logic [31:0] v, string nm);
    q.push_back('{cyc + dc, s, v, nm});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int a0, int a1);
    raddr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*5 +: 5] = 5'(a);
    wdata[p*32 +: 32] = d;
  endtask

  task automatic nowr();
    we = '0;
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].nm, sel(q[i].sig), q[i].val);
        q.delete(i);
      end
    end
    if (dv1 && dbg_ready) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump_extra: got idx %0d want none", didx1);
      end else begin
        de = dq.pop_front();
        chk("dump_idx", 32'(didx1), 32'(de.idx));
        chk("dump_data", ddata1, de.val);
      end
    end
    if (ddone1) begin
      done_cnt++;
      chk("done_valid_low", 32'(dv1), 32'h0);
    end
  end

  initial begin
    pc = '0; raddr = '0; waddr = '0; wdata = '0; we = '0;
    dbg_start = 1'b0; dbg_ready = 1'b0;
    step(); step();
    rd(5, 7);
    expect_at(0, RD1_0, 0, "rst_rdata0");
    expect_at(0, RD1_1, 0, "rst_rdata1");
    expect_at(0, BUSY1, 1, "rst_busy");
    expect_at(0, DV, 0, "rst_dv");
    expect_at(0, DIDX, 0, "rst_didx");
    expect_at(0, DDATA, 0, "rst_ddata");
    expect_at(0, DDONE, 0, "rst_ddone");
    step();
    rst = 1'b1;
    expect_at(0, BUSY1, 1, "busy_start");
    expect_at(31, BUSY1, 1, "busy_last");
    expect_at(32, BUSY1, 0, "busy_fall");
    expect_at(32, BUSY0, 0, "busy_fall_c");
    rd(5, 5);
    expect_at(0, RD0_0, 0, "busy_read_c");
    repeat (10) step();
    wr(0, 5, 32'hDEAD);
    expect_at(0, RD0_0, 0, "busy_bypass_blocked");
    expect_at(1, RD1_0, 0, "busy_read_reg");
    step();
    nowr();
    repeat (21) step();
    rd(5, 5);
    expect_at(0, RD0_0, 0, "after_sweep_r5");
    expect_at(1, RD1_1, 0, "after_sweep_r5_reg");
    step();
    wr(0, 7, 32'h1234); rd(7, 7);
    expect_at(0, RD0_0, 32'h1234, "byp_p0");
    expect_at(0, RD0_1, 32'h1234, "byp_p1");
    expect_at(1, RD1_0, 32'h1234, "byp_reg");
    step();
    nowr();
    expect_at(0, RD0_1, 32'h1234, "mem_r7");
    expect_at(1, RD1_1, 32'h1234, "mem_r7_reg");
    step();
    wr(0, 9, 32'hAAAA); wr(1, 9, 32'h5555); rd(9, 9);
    expect_at(0, RD0_0, 32'h5555, "wprio_byp");
    expect_at(1, RD1_0, 32'h5555, "wprio_byp_reg");
    step();
    nowr(); rd(9, 0);
    expect_at(0, RD0_0, 32'h5555, "wprio_mem");
    expect_at(0, RD0_1, 0, "r0");
    expect_at(1, RD1_0, 32'h5555, "wprio_mem_reg");
    step();
    wr(0, 0, 32'hFFFF); wr(1, 1, 32'hFFFF); rd(0, 1);
    expect_at(0, RD0_0, 0, "r0_byp");
    expect_at(0, RD0_1, 1, "r1_byp");
    expect_at(1, RD1_0, 0, "r0_byp_reg");
    expect_at(1, RD1_1, 1, "r1_byp_reg");
    step();
    nowr(); pc = 32'h100; rd(31, 0);
    expect_at(0, RD0_0, 32'h100, "pc_comb");
    expect_at(1, RD1_0, 32'h101, "pc_reg");
    expect_at(0, RD0_1, 0, "r0_after_wr");
    expect_at(1, RD1_1, 0, "r0_after_wr_reg");
    step();
    rd(1, 1); wr(0, 3, 32'h33);
    expect_at(0, RD0_0, 1, "r1_after_wr");
    step();
    nowr(); dbg_start = 1'b1; dbg_ready = 1'b1;
    expect_at(0, DV, 0, "dv_before");
    expect_at(1, DV, 1, "dv_rise");
    for (int i = 0; i < 32; i++) dq.push_back('{i, dump_val(i)});
    step();
    dbg_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      step();
      n++;
      dbg_ready = ~dbg_ready;
      if (n == 1) wr(0, 20, 32'h2020);
      else nowr();
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL dump_timeout: got no done want done");
    end
    repeat (3) step();
    chk("done_pulses", 32'(done_cnt), 32'h1);
    chk("dump_words_left", 32'(dq.size()), 32'h0);
    dbg_start = 1'b1; dbg_ready = 1'b1;
    for (int i = 0; i < 10; i++) dq.push_back('{i, dump_val(i)});
    step();
    dbg_start = 1'b0;
    n = 0;
    while (didx1 != 5'd10 && n < 100) begin
      step();
      n++;
      dbg_ready = ~dbg_ready;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL dump2_timeout: got idx %0d want 10", didx1);
    end
    #1;
    rst = 1'b0;
    expect_at(0, DV, 0, "rst_dv_async");
    expect_at(0, BUSY1, 1, "rst_mid_busy");
    expect_at(0, DIDX, 0, "rst_mid_didx");
    step(); step();
    rst = 1'b1;
    expect_at(31, BUSY1, 1, "busy2_last");
    expect_at(32, BUSY1, 0, "busy2_fall");
    repeat (32) step();
    rd(7, 7);
    expect_at(0, RD0_0, 0, "r7_cleared");
    step(); step();
    chk("dump2_words_left", 32'(dq.size()), 32'h0);
    chk("done_total", 32'(done_cnt), 32'h1);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL unchecked: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
